// File: rtl/restoring_divider_param.sv
// restoring_divider_param: iterative restoring divider with signed/unsigned modes and flags.
//   clk, rst (async, active-low)
//   start, signed_mode, dividend, divisor : request and operands, sampled in IDLE
//   busy, done                            : handshake; done is a one-cycle pulse
//   quotient, remainder                   : results, held until the next result
//   div_by_zero, overflow                 : flags, held with the results
module restoring_divider_param #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow
);
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3;
   logic [1:0]       state;
   logic [WIDTH:0]   a_r, sh, t;
   logic [WIDTH-1:0] q_r, m_r, raw_r, min_v;
   logic [CNT_W-1:0] cnt;
   logic             sd_r, sv_r, dz_r, ov_r, sd, sv, accept;
   always_comb begin
      sh     = {a_r[WIDTH-1:0], q_r[WIDTH-1]};
      t      = sh - {1'b0, m_r};
      sd     = signed_mode & dividend[WIDTH-1];
      sv     = signed_mode & divisor[WIDTH-1];
      min_v  = {1'b1, {(WIDTH-1){1'b0}}};
      // busy also covers the done cycle, where the FSM is already back in IDLE
      accept = (state == IDLE) && start && !busy;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state       <= IDLE;
         a_r         <= '0;
         q_r         <= '0;
         m_r         <= '0;
         raw_r       <= '0;
         cnt         <= '0;
         sd_r        <= 1'b0;
         sv_r        <= 1'b0;
         dz_r        <= 1'b0;
         ov_r        <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         done <= state == DONE;
         if (done) busy <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               busy        <= 1'b1;
               state       <= CALC;
               a_r         <= '0;
               cnt         <= '0;
               // negating MIN yields 2^(WIDTH-1), which is exact when read as unsigned
               q_r         <= sd ? -dividend : dividend;
               m_r         <= sv ? -divisor : divisor;
               raw_r       <= dividend;
               sd_r        <= sd;
               sv_r        <= sv;
               dz_r        <= divisor == '0;
               ov_r        <= signed_mode && dividend == min_v && &divisor;
               div_by_zero <= 1'b0;
               overflow    <= 1'b0;
            end
            CALC: begin
               a_r <= t[WIDTH] ? sh : t;
               q_r <= {q_r[WIDTH-2:0], ~t[WIDTH]};
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
            end
            FIX: begin
               // MIN / -1 needs no special case: |MIN|/1 = 2^(WIDTH-1) reads back as MIN
               quotient    <= dz_r ? '1 : (sd_r ^ sv_r) ? -q_r : q_r;
               remainder   <= dz_r ? raw_r : sd_r ? -a_r[WIDTH-1:0] : a_r[WIDTH-1:0];
               div_by_zero <= dz_r;
               overflow    <= ov_r;
               state       <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_restoring_divider_param.sv
// tb_restoring_divider_param: directed self-checking bench for restoring_divider_param.
module tb_restoring_divider_param;
   logic        clk = 1'b0, rst = 1'b0, start = 1'b0, sm = 1'b0;
   logic [5:0]  dvd = '0, dvs = '0, q, r;
   logic        busy, done, dz, ov;
   logic        start16 = 1'b0;
   logic [15:0] dvd16 = '0, dvs16 = '0, q16, r16;
   logic        busy16, done16, dz16, ov16;
   int          errors = 0, checks = 0, cyc = 0, k = 0, lat = 0;
   logic        saw;

   restoring_divider_param #(.WIDTH(6)) dut (
      .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .dividend(dvd), .divisor(dvs),
      .busy(busy), .done(done), .quotient(q), .remainder(r), .div_by_zero(dz), .overflow(ov));

   restoring_divider_param #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .signed_mode(1'b0), .dividend(dvd16), .divisor(dvs16),
      .busy(busy16), .done(done16), .quotient(q16), .remainder(r16), .div_by_zero(dz16), .overflow(ov16));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic go(input logic s, input logic [5:0] a, input logic [5:0] b);
      @(negedge clk);
      sm = s; dvd = a; dvs = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = cyc;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      lat = cyc - k;
   endtask

   task automatic op(input string tag, input logic s, input logic [5:0] a, input logic [5:0] b,
                     input logic [5:0] eq, input logic [5:0] er, input logic edz, input logic eov);
      go(s, a, b);
      chk({tag, "_busy"}, busy, 1);
      wait_done();
      chk({tag, "_lat"}, lat, 8);
      chk({tag, "_q"}, q, eq);
      chk({tag, "_r"}, r, er);
      chk({tag, "_dz"}, dz, edz);
      chk({tag, "_ov"}, ov, eov);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_out", {busy, done, q, r, dz, ov}, 0);
      chk("rst_out16", {busy16, done16, q16, r16, dz16, ov16}, 0);
      rst = 1'b1;
      op("u45_7", 0, 6'd45, 6'd7, 6'd6, 6'd3, 0, 0);
      @(negedge clk);
      chk("pulse_done", done, 0);
      chk("pulse_busy", busy, 0);
      op("s_m19_7", 1, 6'b101101, 6'b000111, 6'b111110, 6'b111011, 0, 0);
      op("s_19_m7", 1, 6'b010011, 6'b111001, 6'b111110, 6'b000101, 0, 0);
      op("u20_0", 0, 6'd20, 6'd0, 6'b111111, 6'd20, 1, 0);
      op("s_m32_m1", 1, 6'b100000, 6'b111111, 6'b100000, 6'd0, 0, 1);
      op("s_m32_1", 1, 6'b100000, 6'b000001, 6'b100000, 6'd0, 0, 0);
      op("u63_63", 0, 6'd63, 6'd63, 6'd1, 6'd0, 0, 0);
      op("s_m1_0", 1, 6'b111111, 6'd0, 6'b111111, 6'b111111, 1, 0);
      op("u5_9", 0, 6'd5, 6'd9, 6'd0, 6'd5, 0, 0);
      go(0, 6'd45, 6'd7);
      repeat (2) @(negedge clk);
      sm = 1'b1; dvd = 6'd63; dvs = 6'd8; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      chk("mid_lat", lat, 8);
      chk("mid_q", q, 6);
      chk("mid_r", r, 3);
      go(0, 6'd63, 6'd8);
      wait_done();
      chk("u63_8_q", q, 7);
      chk("u63_8_r", r, 7);
      dvd = 6'd10; dvs = 6'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_in_done", busy, 0);
      go(0, 6'd45, 6'd7);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_mid", {busy, done, q, r, dz, ov}, 0);
      saw = 1'b0;
      repeat (12) begin
         @(negedge clk);
         saw |= done;
      end
      chk("rst_no_done", saw, 0);
      rst = 1'b1;
      op("post_rst_63_8", 0, 6'd63, 6'd8, 6'd7, 6'd7, 0, 0);
      @(negedge clk);
      dvd16 = 16'd65535; dvs16 = 16'd255; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      k = cyc;
      for (int n = 0; n < 60 && !done16; n++) @(negedge clk);
      lat = cyc - k;
      chk("w16_lat", lat, 18);
      chk("w16_q", q16, 257);
      chk("w16_r", r16, 0);
      chk("w16_flags", {dz16, ov16}, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
